// File: rtl/geofence_feeder.sv
`default_nettype none
// ============================================================================
// Module   : geofence_feeder
// Purpose  : Stores point sets and streams them into a geofence engine,
//            collecting one inside/outside result per set.
//            Optional WAIT watchdog: define GEOFENCE_FEEDER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module geofence_feeder #(
  parameter int MAX_SETS = 8,
  parameter int SET_W    = 3
`ifdef GEOFENCE_FEEDER_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [SET_W:0]      num_sets,
  input  logic                ld_en,
  input  logic [SET_W-1:0]    ld_set,
  input  logic [2:0]          ld_pt,
  input  logic [9:0]          ld_x,
  input  logic [9:0]          ld_y,
  output logic                gf_reset,
  output logic [9:0]          X,
  output logic [9:0]          Y,
  input  logic                valid,
  input  logic                is_inside,
  output logic                busy,
  output logic                res_valid,
  output logic                res_inside,
  output logic [SET_W-1:0]    res_set,
  output logic [MAX_SETS-1:0] inside_vec,
  output logic                done,
  output logic                timeout_err
);

  localparam int              c_DEPTH   = 7 * MAX_SETS;
  localparam int              c_AW      = $clog2(c_DEPTH);
  localparam logic [SET_W:0]  c_MAX_N   = (SET_W+1)'(MAX_SETS);
  localparam logic [2:0]      c_LAST_PT = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                r_state, w_state;
  logic [SET_W-1:0]      r_set, w_set, r_last, w_last;
  logic [2:0]            r_pt, w_pt;
  logic [9:0]            r_x, w_x, r_y, w_y;
  logic                  r_gf_reset, w_gf_reset;
  logic                  r_res_valid, w_res_valid;
  logic                  r_res_inside, w_res_inside;
  logic [SET_W-1:0]      r_res_set, w_res_set;
  logic [MAX_SETS-1:0]   r_vec, w_vec;
  logic                  r_done, w_done;

  logic [19:0]           r_mem [c_DEPTH];
  logic                  w_wr_en;
  logic [c_AW-1:0]       w_wr_addr, w_rd_addr;
  logic [19:0]           w_rd_data;
  logic [SET_W:0]        w_nsets;

`ifdef GEOFENCE_FEEDER_TIMEOUT_EN
  localparam int         c_TW = $clog2(TIMEOUT + 1);
  logic [c_TW-1:0]       r_wcnt, w_wcnt;
  logic                  r_to_err, w_to_err;
`endif

  function automatic logic [c_AW-1:0] pt_addr(input logic [SET_W-1:0] s, input logic [2:0] p);
    return c_AW'(s) * c_AW'(7) + c_AW'(p);
  endfunction

  // Point memory has no reset so loaded sets survive a reset.
  assign w_wr_en   = (r_state == S_IDLE) && ld_en && (ld_pt != 3'd7) && ({1'b0, ld_set} < c_MAX_N);
  assign w_wr_addr = pt_addr(ld_set, ld_pt);

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= {ld_x, ld_y};
  end

  always_comb begin
    w_rd_addr = pt_addr('0, 3'd0);
    case (r_state)
      S_SEND:  w_rd_addr = pt_addr(r_set, (r_pt == c_LAST_PT) ? c_LAST_PT : r_pt + 3'd1);
      S_WAIT:  w_rd_addr = pt_addr(r_set + SET_W'(1), 3'd0);
      default: w_rd_addr = pt_addr('0, 3'd0);
    endcase
  end

  // Bypass lets a load issued together with start reach the first object.
  assign w_rd_data = (w_wr_en && (w_wr_addr == w_rd_addr)) ? {ld_x, ld_y} : r_mem[w_rd_addr];
  assign w_nsets   = (num_sets > c_MAX_N) ? c_MAX_N : num_sets;

  always_comb begin
    w_state      = r_state;
    w_set        = r_set;
    w_last       = r_last;
    w_pt         = r_pt;
    w_x          = r_x;
    w_y          = r_y;
    w_gf_reset   = r_gf_reset;
    w_res_valid  = 1'b0;
    w_res_inside = r_res_inside;
    w_res_set    = r_res_set;
    w_vec        = r_vec;
    w_done       = 1'b0;
`ifdef GEOFENCE_FEEDER_TIMEOUT_EN
    w_wcnt       = r_wcnt;
    w_to_err     = r_to_err;
`endif
    case (r_state)
      S_IDLE: begin
        w_gf_reset = 1'b1;
        w_x        = '0;
        w_y        = '0;
        if (start) begin
`ifdef GEOFENCE_FEEDER_TIMEOUT_EN
          w_to_err = 1'b0;
`endif
          if (w_nsets == '0) begin
            w_done = 1'b1;
          end else begin
            w_vec      = '0;
            w_set      = '0;
            w_pt       = '0;
            w_last     = SET_W'(w_nsets - (SET_W+1)'(1));
            w_x        = w_rd_data[19:10];
            w_y        = w_rd_data[9:0];
            w_gf_reset = 1'b0;
            w_state    = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (r_pt == c_LAST_PT) begin
          w_state = S_WAIT;
`ifdef GEOFENCE_FEEDER_TIMEOUT_EN
          w_wcnt  = '0;
`endif
        end else begin
          w_pt = r_pt + 3'd1;
          w_x  = w_rd_data[19:10];
          w_y  = w_rd_data[9:0];
        end
      end
      S_WAIT: begin
        if (valid) begin
          w_res_valid  = 1'b1;
          w_res_inside = is_inside;
          w_res_set    = r_set;
          w_vec[r_set] = is_inside;
          if (r_set == r_last) begin
            w_done     = 1'b1;
            w_state    = S_IDLE;
            w_gf_reset = 1'b1;
            w_x        = '0;
            w_y        = '0;
          end else begin
            // Next object goes out on the valid edge: the engine latches it one cycle later.
            w_set   = r_set + SET_W'(1);
            w_pt    = '0;
            w_x     = w_rd_data[19:10];
            w_y     = w_rd_data[9:0];
            w_state = S_SEND;
          end
        end
`ifdef GEOFENCE_FEEDER_TIMEOUT_EN
        else if (r_wcnt == c_TW'(TIMEOUT - 1)) begin
          w_to_err   = 1'b1;
          w_done     = 1'b1;
          w_state    = S_IDLE;
          w_gf_reset = 1'b1;
          w_x        = '0;
          w_y        = '0;
        end else begin
          w_wcnt = r_wcnt + c_TW'(1);
        end
`endif
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_set        <= '0;
      r_last       <= '0;
      r_pt         <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_gf_reset   <= 1'b1;
      r_res_valid  <= 1'b0;
      r_res_inside <= 1'b0;
      r_res_set    <= '0;
      r_vec        <= '0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_set        <= w_set;
      r_last       <= w_last;
      r_pt         <= w_pt;
      r_x          <= w_x;
      r_y          <= w_y;
      r_gf_reset   <= w_gf_reset;
      r_res_valid  <= w_res_valid;
      r_res_inside <= w_res_inside;
      r_res_set    <= w_res_set;
      r_vec        <= w_vec;
      r_done       <= w_done;
    end
  end

`ifdef GEOFENCE_FEEDER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt   <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_wcnt   <= w_wcnt;
      r_to_err <= w_to_err;
    end
  end
  assign timeout_err = r_to_err;
`else
  assign timeout_err = 1'b0;
`endif

  assign gf_reset   = r_gf_reset;
  assign X          = r_x;
  assign Y          = r_y;
  assign busy       = (r_state != S_IDLE);
  assign res_valid  = r_res_valid;
  assign res_inside = r_res_inside;
  assign res_set    = r_res_set;
  assign inside_vec = r_vec;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_geofence_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_geofence_feeder
// Purpose  : Randomized bench for geofence_feeder with a behavioural engine
//            and point-in-hexagon reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_geofence_feeder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] num_sets = '0;
  logic       ld_en = 1'b0;
  logic [2:0] ld_set = '0;
  logic [2:0] ld_pt = '0;
  logic [9:0] ld_x = '0;
  logic [9:0] ld_y = '0;
  logic       gf_reset;
  logic [9:0] X, Y;
  logic       valid = 1'b0;
  logic       is_inside = 1'b0;
  logic       busy, res_valid, res_inside, done, timeout_err;
  logic [2:0] res_set;
  logic [7:0] inside_vec;

  int n_tests = 0;
  int n_fail  = 0;

  int ex [8][7];
  int ey [8][7];
  int capx [7];
  int capy [7];
  int ecnt = 0, eset = 0, edly = 0;
  bit kill = 1'b0;

  geofence_feeder dut (
    .clk(clk), .reset(reset), .start(start), .num_sets(num_sets),
    .ld_en(ld_en), .ld_set(ld_set), .ld_pt(ld_pt), .ld_x(ld_x), .ld_y(ld_y),
    .gf_reset(gf_reset), .X(X), .Y(Y), .valid(valid), .is_inside(is_inside),
    .busy(busy), .res_valid(res_valid), .res_inside(res_inside), .res_set(res_set),
    .inside_vec(inside_vec), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] pt20(input int s, input int p);
    int vx, vy;
    vx = ex[s][p];
    vy = ey[s][p];
    return {vx[9:0], vy[9:0]};
  endfunction

  // Object strictly inside a convex hexagon: all edge cross products share a sign.
  function automatic bit pip(input int s, input bit cap);
    int px[7], py[7];
    int pos = 0, neg = 0;
    for (int k = 0; k < 7; k++) begin
      px[k] = cap ? capx[k] : ex[s][k];
      py[k] = cap ? capy[k] : ey[s][k];
    end
    for (int i = 1; i <= 6; i++) begin
      int j = (i == 6) ? 1 : i + 1;
      int c = (px[j]-px[i])*(py[0]-py[i]) - (py[j]-py[i])*(px[0]-px[i]);
      if (c > 0) pos++;
      else if (c < 0) neg++;
    end
    return (pos == 6) || (neg == 6);
  endfunction

  // Engine model: latches 7 points while out of reset, answers after a random delay.
  always @(negedge clk) begin
    if (reset || gf_reset) begin
      ecnt  = 0;
      eset  = 0;
      valid = 1'b0;
    end else begin
      if (valid) begin
        valid = 1'b0;
        ecnt  = 0;
        eset++;
      end
      if (ecnt < 7) begin
        capx[ecnt] = int'(X);
        capy[ecnt] = int'(Y);
        check("stream_pt", {X, Y}, pt20(eset, ecnt));
        ecnt++;
        if (ecnt == 7) edly = $urandom_range(0, 3);
      end else if (!kill) begin
        if (edly == 0) begin
          valid     = 1'b1;
          is_inside = pip(0, 1'b1);
        end else begin
          edly--;
        end
      end
    end
  end

  task automatic load(input int s, input int p, input int x, input int y);
    ld_en  = 1'b1;
    ld_set = 3'(s);
    ld_pt  = 3'(p);
    ld_x   = 10'(x);
    ld_y   = 10'(y);
    if (p != 7) begin
      ex[s][p] = x;
      ey[s][p] = y;
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic load_hex(input int s, input int cx, input int cy, input int r, input int ox, input int oy);
    load(s, 0, ox, oy);
    load(s, 1, cx - r/2, cy - r);
    load(s, 2, cx + r/2, cy - r);
    load(s, 3, cx + r,   cy);
    load(s, 4, cx + r/2, cy + r);
    load(s, 5, cx - r/2, cy + r);
    load(s, 6, cx - r,   cy);
  endtask

  task automatic rand_sets();
    for (int s = 0; s < 8; s++) begin
      int cx = $urandom_range(150, 850);
      int cy = $urandom_range(150, 850);
      int r  = $urandom_range(30, 120);
      load_hex(s, cx, cy, r, cx - r - 10 + $urandom_range(0, 2*r + 20),
                             cy - r - 10 + $urandom_range(0, 2*r + 20));
    end
    load($urandom_range(0, 7), 7, $urandom_range(0, 1023), $urandom_range(0, 1023));
  endtask

  task automatic do_run(input int nreq, input bit noise);
    int n = (nreq > 8) ? 8 : nreq;
    logic [7:0] expv = '0;
    int got = 0, cyc = 0;
    bit fin = 1'b0, e;
    start    = 1'b1;
    num_sets = 4'(nreq);
    @(negedge clk);
    start = 1'b0;
    ld_en = 1'b0;
    if (n == 0) begin
      check("zero_done", done, 1);
      check("zero_gfrst", gf_reset, 1);
      check("zero_busy", busy, 0);
      check("zero_resv", res_valid, 0);
      @(negedge clk);
      check("zero_done_once", done, 0);
      check("zero_resv2", res_valid, 0);
      return;
    end
    check("start_gfrst", gf_reset, 0);
    check("start_obj", {X, Y}, pt20(0, 0));
    check("start_toerr", timeout_err, 0);
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      ld_en = 1'b0;
      if (noise && busy) begin
        start  = 1'($urandom);
        ld_en  = 1'($urandom);
        ld_set = 3'($urandom);
        ld_pt  = 3'($urandom);
        ld_x   = 10'($urandom);
        ld_y   = 10'($urandom);
      end
      if (res_valid) begin
        e = pip(got < 8 ? got : 7, 1'b0);
        check("res_set", res_set, got);
        check("res_inside", res_inside, e);
        expv[got < 8 ? got : 7] = e;
        if (got < n - 1) check("next_obj", {X, Y}, pt20(got + 1, 0));
        got++;
      end
      if (done) begin
        fin = 1'b1;
        check("done_with_res", res_valid, 1);
      end
    end
    start = 1'b0;
    ld_en = 1'b0;
    if (!fin) check("run_bound", 0, 1);
    check("res_count", got, n);
    check("inside_vec", inside_vec, expv);
    check("end_busy", busy, 0);
    check("end_gfrst", gf_reset, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_gfrst", gf_reset, 1);
    check("rst_x", X, 0);
    check("rst_y", Y, 0);
    check("rst_busy", busy, 0);
    check("rst_resv", res_valid, 0);
    check("rst_resin", res_inside, 0);
    check("rst_resset", res_set, 0);
    check("rst_vec", inside_vec, 0);
    check("rst_done", done, 0);
    check("rst_toerr", timeout_err, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed: single inside set, then inside + outside back to back.
    load_hex(0, 50, 50, 30, 50, 50);
    load(0, 1, 40, 20); load(0, 2, 60, 20); load(0, 3, 70, 50);
    load(0, 4, 60, 80); load(0, 5, 40, 80); load(0, 6, 30, 50);
    do_run(1, 1'b0);
    for (int p = 1; p < 7; p++) load(1, p, ex[0][p], ey[0][p]);
    load(1, 0, 100, 100);
    do_run(2, 1'b0);
    do_run(0, 1'b0);

    // Load of the first object in the same cycle as start.
    ld_en = 1'b1; ld_set = 3'd0; ld_pt = 3'd0; ld_x = 10'd100; ld_y = 10'd100;
    ex[0][0] = 100; ey[0][0] = 100;
    do_run(1, 1'b0);
    load(0, 0, 50, 50);

    // Reset while the fourth point of set 0 is on the bus.
    start = 1'b1; num_sets = 4'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_pt3", {X, Y}, pt20(0, 3));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_gfrst", gf_reset, 1);
    check("mid_busy", busy, 0);
    check("mid_xy", {X, Y}, 0);
    check("mid_done", done, 0);
    check("mid_vec", inside_vec, 0);
    @(negedge clk);
    check("mid_done2", done, 0);
    do_run(2, 1'b0);

    // Clamp, then randomized runs with ignored start/load noise while busy.
    rand_sets();
    do_run(15, 1'b0);
    for (int it = 0; it < 6; it++) begin
      rand_sets();
      do_run($urandom_range(0, 15), 1'b1);
    end

`ifdef GEOFENCE_FEEDER_TIMEOUT_EN
    begin
      int cyc = 0, rv = 0;
      kill  = 1'b1;
      start = 1'b1; num_sets = 4'd1;
      @(negedge clk);
      start = 1'b0;
      while (!done && cyc < 200) begin
        @(negedge clk);
        cyc++;
        if (res_valid) rv++;
      end
      check("to_latency", cyc, 71);
      check("to_err", timeout_err, 1);
      check("to_no_res", rv, 0);
      check("to_gfrst", gf_reset, 1);
      kill = 1'b0;
      @(negedge clk);
      check("to_sticky", timeout_err, 1);
      do_run(1, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
